// File: rtl/ad9231_cfg_sequencer.sv
// AD9231 SPI configuration sequencer: runs the boot register table after reset,
// serves runtime host register writes and gates the ADC data-capture path.
// A single 24-bit write serializer is shared by boot, restart and host traffic.
`timescale 1ns/1ps
module ad9231_cfg_sequencer #(
    parameter int unsigned CLK_DIV   = 10,
    parameter int unsigned CS_GAP    = 20,
    parameter logic [7:0]  REG14_VAL = 8'h20,
    parameter logic [7:0]  REG2E_VAL = 8'h00
) (
    input  logic        clk_200m,
    input  logic        rst,
    input  logic        restart,
    input  logic        host_req,
    input  logic [12:0] host_addr,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        spi_sclk,
    output logic        spi_csb,
    output logic        spi_sdio,
    output logic        busy,
    output logic        cfg_done,
    output logic        adc_read_enable
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [4:0]       BIT_LAST = 5'd23;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_BOOT = 3'd1,
        SEQ_RUN  = 3'd2,
        SEQ_HOST = 3'd3,
        SEQ_ACK  = 3'd4
    } seq_state_t;

    typedef enum logic [2:0] {
        SER_IDLE = 3'd0,
        SER_LEAD = 3'd1,
        SER_HIGH = 3'd2,
        SER_LOW  = 3'd3,
        SER_TAIL = 3'd4,
        SER_GAP  = 3'd5
    } ser_state_t;

    // Frame word for the entry the sequencer is about to launch:
    // R/W=0, W1:W0=00, 13-bit address, 8-bit data.
    function automatic logic [23:0] frame_word(input seq_state_t st,
                                               input logic [1:0]  idx,
                                               input logic [12:0] haddr,
                                               input logic [7:0]  hdata);
        logic [12:0] a;
        logic [7:0]  d;
        a = 13'h0FF;
        d = 8'h01;
        case (st)
            SEQ_BOOT: begin
                case (idx)
                    2'd0:    begin a = 13'h014; d = REG14_VAL; end
                    2'd1:    begin a = 13'h02E; d = REG2E_VAL; end
                    default: begin a = 13'h0FF; d = 8'h01;     end
                endcase
            end
            SEQ_HOST: begin
                if (idx == 2'd0) begin
                    a = haddr;
                    d = hdata;
                end else begin
                    a = 13'h0FF;
                    d = 8'h01;
                end
            end
            default: begin
                a = 13'h0FF;
                d = 8'h01;
            end
        endcase
        return {1'b0, 2'b00, a, d};
    endfunction

    seq_state_t        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic              issued_q, issued_d;
    logic              done_seen_q, done_seen_d;
    logic              cfg_done_q, cfg_done_d;
    logic              busy_q, busy_d;
    logic              adc_en_q, adc_en_d;
    logic              host_ack_q, host_ack_d;

    ser_state_t        ser_q, ser_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [22:0]       shift_q, shift_d;
    logic              sclk_q, sclk_d;
    logic              csb_q, csb_d;
    logic              sdio_q, sdio_d;
    logic              fr_done_q, fr_done_d;

    logic              fr_start_s;
    logic [23:0]       fr_word_s;
    logic              ser_ready_s;
    logic              frame_over_s;
    logic              host_last_s;

    // The serializer accepts a new frame once idle or in the last gap cycle,
    // so back-to-back frames see exactly CS_GAP cycles of chip-select high.
    assign ser_ready_s  = (ser_q == SER_IDLE) || ((ser_q == SER_GAP) && (gap_q == GAP_LAST));
    assign frame_over_s = issued_q && (done_seen_q || fr_done_q) && ser_ready_s;
    assign host_last_s  = (idx_q == 2'd1) || (host_addr == 13'h0FF);

    // Sequencer next state: boot table, run, host write with optional transfer frame.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        issued_d    = issued_q;
        done_seen_d = done_seen_q | fr_done_q;
        cfg_done_d  = cfg_done_q;
        fr_start_s  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                state_d     = SEQ_BOOT;
                idx_d       = 2'd0;
                issued_d    = 1'b0;
                done_seen_d = 1'b0;
            end
            SEQ_BOOT: begin
                if (!issued_q) begin
                    if (ser_ready_s) begin
                        fr_start_s  = 1'b1;
                        issued_d    = 1'b1;
                        done_seen_d = 1'b0;
                    end else begin
                        fr_start_s  = 1'b0;
                    end
                end else if (frame_over_s) begin
                    if (idx_q == 2'd2) begin
                        cfg_done_d  = 1'b1;
                        state_d     = SEQ_RUN;
                        issued_d    = 1'b0;
                        done_seen_d = 1'b0;
                    end else begin
                        idx_d       = idx_q + 2'd1;
                        fr_start_s  = 1'b1;
                        done_seen_d = 1'b0;
                    end
                end else begin
                    fr_start_s = 1'b0;
                end
            end
            SEQ_HOST: begin
                if (!issued_q) begin
                    if (ser_ready_s) begin
                        fr_start_s  = 1'b1;
                        issued_d    = 1'b1;
                        done_seen_d = 1'b0;
                    end else begin
                        fr_start_s  = 1'b0;
                    end
                end else if (frame_over_s) begin
                    if (host_last_s) begin
                        state_d     = SEQ_ACK;
                        issued_d    = 1'b0;
                        done_seen_d = 1'b0;
                    end else begin
                        idx_d       = 2'd1;
                        fr_start_s  = 1'b1;
                        done_seen_d = 1'b0;
                    end
                end else begin
                    fr_start_s = 1'b0;
                end
            end
            SEQ_ACK: begin
                state_d  = SEQ_RUN;
                issued_d = 1'b0;
            end
            SEQ_RUN: begin
                // restart wins over a simultaneous host request; the request stays pending
                if (restart) begin
                    state_d    = SEQ_BOOT;
                    idx_d      = 2'd0;
                    cfg_done_d = 1'b0;
                    issued_d   = 1'b0;
                end else if (host_req) begin
                    state_d  = SEQ_HOST;
                    idx_d    = 2'd0;
                    issued_d = 1'b0;
                end else begin
                    state_d = SEQ_RUN;
                end
            end
            default: begin
                state_d     = SEQ_IDLE;
                idx_d       = 2'd0;
                issued_d    = 1'b0;
                done_seen_d = 1'b0;
            end
        endcase
        // Outputs follow the next state so they change on the same edge as the state.
        busy_d     = (state_d == SEQ_BOOT) || (state_d == SEQ_HOST) || (state_d == SEQ_ACK);
        adc_en_d   = (state_d == SEQ_RUN);
        host_ack_d = (state_d == SEQ_ACK);
        fr_word_s  = frame_word(state_d, idx_d, host_addr, host_data);
    end

    // Serializer next state: lead-in, 24 SCLK periods, tail, then chip-select gap.
    always_comb begin
        ser_d     = ser_q;
        div_d     = div_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        csb_d     = csb_q;
        sdio_d    = sdio_q;
        fr_done_d = 1'b0;
        case (ser_q)
            SER_IDLE: begin
                if (fr_start_s) begin
                    shift_d = fr_word_s[22:0];
                    sdio_d  = fr_word_s[23];
                    csb_d   = 1'b0;
                    div_d   = DIV_ZERO;
                    bit_d   = 5'd0;
                    ser_d   = SER_LEAD;
                end else begin
                    ser_d = SER_IDLE;
                end
            end
            SER_LEAD: begin
                if (div_q == DIV_LAST) begin
                    div_d  = DIV_ZERO;
                    sclk_d = 1'b1;
                    ser_d  = SER_HIGH;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            SER_HIGH: begin
                // falling SCLK edge: present the next bit
                if (div_q == DIV_LAST) begin
                    div_d   = DIV_ZERO;
                    sclk_d  = 1'b0;
                    sdio_d  = shift_q[22];
                    shift_d = {shift_q[21:0], 1'b0};
                    ser_d   = SER_LOW;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            SER_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d = DIV_ZERO;
                    if (bit_q == BIT_LAST) begin
                        ser_d = SER_TAIL;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        sclk_d = 1'b1;
                        ser_d  = SER_HIGH;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            SER_TAIL: begin
                if (div_q == DIV_LAST) begin
                    div_d     = DIV_ZERO;
                    csb_d     = 1'b1;
                    sdio_d    = 1'b0;
                    fr_done_d = 1'b1;
                    gap_d     = GAP_ZERO;
                    ser_d     = SER_GAP;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            SER_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (fr_start_s) begin
                        shift_d = fr_word_s[22:0];
                        sdio_d  = fr_word_s[23];
                        csb_d   = 1'b0;
                        div_d   = DIV_ZERO;
                        bit_d   = 5'd0;
                        ser_d   = SER_LEAD;
                    end else begin
                        ser_d = SER_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            default: begin
                ser_d  = SER_IDLE;
                csb_d  = 1'b1;
                sclk_d = 1'b0;
                sdio_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset idles the SPI pins immediately, even mid-frame.
    always_ff @(posedge clk_200m or posedge rst) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            idx_q       <= 2'd0;
            issued_q    <= 1'b0;
            done_seen_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            adc_en_q    <= 1'b0;
            host_ack_q  <= 1'b0;
            ser_q       <= SER_IDLE;
            div_q       <= DIV_ZERO;
            bit_q       <= 5'd0;
            gap_q       <= GAP_ZERO;
            shift_q     <= 23'd0;
            sclk_q      <= 1'b0;
            csb_q       <= 1'b1;
            sdio_q      <= 1'b0;
            fr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            issued_q    <= issued_d;
            done_seen_q <= done_seen_d;
            cfg_done_q  <= cfg_done_d;
            busy_q      <= busy_d;
            adc_en_q    <= adc_en_d;
            host_ack_q  <= host_ack_d;
            ser_q       <= ser_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            shift_q     <= shift_d;
            sclk_q      <= sclk_d;
            csb_q       <= csb_d;
            sdio_q      <= sdio_d;
            fr_done_q   <= fr_done_d;
        end
    end

    assign host_ack        = host_ack_q;
    assign spi_sclk        = sclk_q;
    assign spi_csb         = csb_q;
    assign spi_sdio        = sdio_q;
    assign busy            = busy_q;
    assign cfg_done        = cfg_done_q;
    assign adc_read_enable = adc_en_q;

endmodule

// File: tb/tb_ad9231_cfg_sequencer.sv
// Bench for ad9231_cfg_sequencer: decodes SPI frames from the pins and checks
// them against an expected-frame list built from the register-write rules.
`timescale 1ns/1ps
module tb_ad9231_cfg_sequencer;

    localparam int CLK_DIV = 10;
    localparam int CS_GAP  = 20;

    logic        clk_200m;
    logic        rst;
    logic        restart;
    logic        host_req;
    logic [12:0] host_addr;
    logic [7:0]  host_data;
    logic        host_ack;
    logic        spi_sclk;
    logic        spi_csb;
    logic        spi_sdio;
    logic        busy;
    logic        cfg_done;
    logic        adc_read_enable;

    ad9231_cfg_sequencer #(
        .CLK_DIV  (CLK_DIV),
        .CS_GAP   (CS_GAP),
        .REG14_VAL(8'h20),
        .REG2E_VAL(8'h00)
    ) dut (
        .clk_200m       (clk_200m),
        .rst            (rst),
        .restart        (restart),
        .host_req       (host_req),
        .host_addr      (host_addr),
        .host_data      (host_data),
        .host_ack       (host_ack),
        .spi_sclk       (spi_sclk),
        .spi_csb        (spi_csb),
        .spi_sdio       (spi_sdio),
        .busy           (busy),
        .cfg_done       (cfg_done),
        .adc_read_enable(adc_read_enable)
    );

    initial clk_200m = 1'b0;
    always #2.5 clk_200m = ~clk_200m;

    typedef struct {
        logic [23:0] word;
        bit          consec;
    } exp_t;

    typedef struct {
        logic [23:0] word;
        int          nbits;
        int          low;
        int          gap;
        bit          tok;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // monitor state
    int          falls    = 0;
    int          m_nbits  = 0;
    int          m_low    = 0;
    int          m_gap    = 1000;
    int          m_fgap   = 0;
    int          m_last   = 0;
    int          m_idle_err = 0;
    bit          m_active = 1'b0;
    bit          m_tok    = 1'b1;
    logic [23:0] m_word   = 24'h0;
    logic        m_pcsb   = 1'b1;
    logic        m_psclk  = 1'b0;
    logic        m_psdio  = 1'b0;

    // Pin-level frame decoder, sampling on the falling clk edge.
    initial begin
        forever begin
            @(negedge clk_200m);
            if (rst) begin
                m_active = 1'b0;
                m_nbits  = 0;
                m_gap    = 1000;
                m_pcsb   = 1'b1;
                m_psclk  = 1'b0;
                m_psdio  = 1'b0;
            end else begin
                if (spi_csb === 1'b0) begin
                    if (m_pcsb === 1'b1) begin
                        falls++;
                        m_active = 1'b1;
                        m_word   = 24'h0;
                        m_nbits  = 0;
                        m_low    = 0;
                        m_tok    = 1'b1;
                        m_fgap   = m_gap;
                        m_last   = 0;
                    end
                    m_low++;
                    if (spi_sclk === 1'b1 && m_psclk === 1'b0) begin
                        m_nbits++;
                        m_word = {m_word[22:0], spi_sdio};
                        if (m_nbits == 1) begin
                            if (m_low != CLK_DIV + 1) m_tok = 1'b0;
                        end else if (m_low - m_last != 2 * CLK_DIV) begin
                            m_tok = 1'b0;
                        end
                        m_last = m_low;
                        if (spi_sdio !== m_psdio) m_tok = 1'b0;
                    end else if (spi_sclk === 1'b1 && spi_sdio !== m_psdio) begin
                        m_tok = 1'b0;
                    end
                end else begin
                    if (spi_sclk !== 1'b0) m_idle_err++;
                    if (m_pcsb === 1'b0) begin
                        if (spi_sdio !== 1'b0) m_tok = 1'b0;
                        if (m_active) obs_q.push_back('{m_word, m_nbits, m_low, m_fgap, m_tok});
                        m_active = 1'b0;
                        m_gap    = 1;
                    end else begin
                        m_gap++;
                    end
                end
                m_pcsb  = spi_csb;
                m_psclk = spi_sclk;
                m_psdio = spi_sdio;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_200m);
        #0.5;
    endtask

    // Reference model: what frames each operation must put on the wire.
    task automatic push_boot();
        exp_q.push_back('{24'h001420, 1'b0});
        exp_q.push_back('{24'h002E00, 1'b1});
        exp_q.push_back('{24'h00FF01, 1'b1});
    endtask

    task automatic push_host(input logic [12:0] a, input logic [7:0] d);
        exp_q.push_back('{{3'b000, a, d}, 1'b0});
        if (a != 13'h0FF) exp_q.push_back('{24'h00FF01, 1'b1});
    endtask

    task automatic compare_frames(input string tag);
        exp_t e;
        obs_t o;
        check({tag, "_frame_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_word"}, o.word, e.word);
            check({tag, "_nbits"}, o.nbits, 24);
            check({tag, "_csb_low"}, o.low, 50 * CLK_DIV);
            check({tag, "_sclk_timing"}, o.tok, 1);
            if (e.consec) check({tag, "_gap"}, o.gap, CS_GAP);
            else          check({tag, "_gap_min"}, 32'(o.gap >= CS_GAP), 1);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic serve_ack(input string tag);
        int n;
        n = 0;
        while (host_ack !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_ack_seen"}, host_ack, 1);
        check({tag, "_ack_adc_low"}, adc_read_enable, 0);
        host_req = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, host_ack, 0);
        check({tag, "_run_adc"}, adc_read_enable, 1);
        check({tag, "_run_busy"}, busy, 0);
    endtask

    task automatic host_write(input logic [12:0] a, input logic [7:0] d, input string tag);
        host_addr = a;
        host_data = d;
        host_req  = 1'b1;
        push_host(a, d);
        tick();
        check({tag, "_adc_drop"}, adc_read_enable, 0);
        check({tag, "_busy"}, busy, 1);
        serve_ack(tag);
        compare_frames(tag);
    endtask

    task automatic wait_boot(input string tag);
        int cyc;
        cyc = 0;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (cfg_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check({tag, "_boot_window"}, 32'(cyc >= 1550 && cyc <= 1575), 1);
        check({tag, "_boot_adc"}, adc_read_enable, 1);
    endtask

    logic [12:0] ha;
    logic [7:0]  hd;
    int          f0;
    int          n;

    initial begin
        rst       = 1'b1;
        restart   = 1'b0;
        host_req  = 1'b0;
        host_addr = 13'h0;
        host_data = 8'h0;
        repeat (3) tick();
        check("rst_csb", spi_csb, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_sdio", spi_sdio, 0);
        check("rst_ack", host_ack, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_adc", adc_read_enable, 0);
        check("rst_busy", busy, 0);

        // Boot with a host request raised at cycle 100: served once, after boot.
        push_boot();
        ha = 13'($urandom_range(0, 8191));
        if (ha == 13'h0FF) ha = 13'h100;
        hd = 8'($urandom);
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (i == 50) begin
                check("boot_busy", busy, 1);
                check("boot_adc", adc_read_enable, 0);
                check("boot_cfg_done", cfg_done, 0);
            end
            if (i == 100) begin
                host_addr = ha;
                host_data = hd;
                host_req  = 1'b1;
                push_host(ha, hd);
            end
            if (cfg_done === 1'b1) begin
                n = i;
                break;
            end
        end
        check("boot0_window", 32'(n >= 1550 && n <= 1575), 1);
        check("boot0_adc", adc_read_enable, 1);
        serve_ack("pend");
        compare_frames("boot_pend");

        host_write(13'h014, 8'h31, "hw14");
        host_write(13'h0FF, 8'($urandom), "hwff");

        // restart and host_req together: full boot first, then the host write.
        ha = 13'($urandom_range(0, 254));
        hd = 8'($urandom);
        push_boot();
        push_host(ha, hd);
        host_addr = ha;
        host_data = hd;
        host_req  = 1'b1;
        restart   = 1'b1;
        tick();
        restart = 1'b0;
        check("simul_cfg_clr", cfg_done, 0);
        check("simul_adc", adc_read_enable, 0);
        check("simul_busy", busy, 1);
        wait_boot("simul");
        serve_ack("simul");
        compare_frames("simul");

        // restart while a host write is in flight is ignored.
        ha = 13'($urandom_range(256, 8191));
        hd = 8'($urandom);
        host_addr = ha;
        host_data = hd;
        host_req  = 1'b1;
        push_host(ha, hd);
        repeat (200) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("ign_restart_cfg", cfg_done, 1);
        serve_ack("ign");
        compare_frames("ign");

        // Randomised host writes, some targeting the transfer register directly.
        for (int k = 0; k < 4; k++) begin
            ha = ($urandom_range(0, 3) == 0) ? 13'h0FF : 13'($urandom_range(0, 8191));
            hd = 8'($urandom);
            host_write(ha, hd, "rand");
        end

        // Reset in the middle of boot frame 1, then a clean reboot.
        f0 = falls;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n = 0;
        while (falls < f0 + 2 && n < 2000) begin
            tick();
            n++;
        end
        check("mid_frame1_seen", falls, f0 + 2);
        n = 0;
        while (m_nbits < 10 && n < 400) begin
            tick();
            n++;
        end
        check("mid_bit10", m_nbits, 10);
        #1;
        rst = 1'b1;
        #0.5;
        check("mid_rst_csb", spi_csb, 1);
        check("mid_rst_sclk", spi_sclk, 0);
        check("mid_rst_sdio", spi_sdio, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cfg", cfg_done, 0);
        check("mid_rst_adc", adc_read_enable, 0);
        check("mid_rst_ack", host_ack, 0);
        repeat (3) tick();
        exp_q.delete();
        obs_q.delete();
        push_boot();
        rst = 1'b0;
        wait_boot("reboot");
        tick();
        compare_frames("reboot");
        check("sclk_idle_high", m_idle_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
